// File: rtl/video_timing_gen.sv
// Raster timing generator: blank/hsync/vsync, pixel coordinates and line/frame strobes.
// Optional colour-bar outputs when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int COORD_W   = 12,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               blank_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               line_start_out,
  output logic               frame_start_out
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic               primed;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               blank_nxt;
  logic               hsync_act;
  logic               vsync_act;

  // Until primed, the next position is (0,0) without advancing.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (primed) begin
      if (x_out == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_out == V_LAST) ? '0 : y_out + 1'b1;
      end else begin
        x_nxt = x_out + 1'b1;
        y_nxt = y_out;
      end
    end
  end

  assign blank_nxt = (x_nxt >= H_ACT) | (y_nxt >= V_ACT);
  assign hsync_act = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
  assign vsync_act = (y_nxt >= VS_BEG) && (y_nxt < VS_END);

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [2:0]    bar_idx, bar_nxt;
  logic [BW-1:0] bar_cnt, cnt_nxt;
  logic [23:0]   rgb_nxt;

  // Bar counter tracks x_nxt one pixel at a time; it idles once past the active area.
  always_comb begin
    bar_nxt = bar_idx;
    cnt_nxt = bar_cnt;
    if (x_nxt == '0) begin
      bar_nxt = '0;
      cnt_nxt = '0;
    end else if (x_nxt < H_ACT) begin
      if (bar_cnt == BAR_LAST) begin
        bar_nxt = bar_idx + 3'd1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rgb_nxt = 24'h000000;
    if (!blank_nxt) begin
      case (bar_nxt)
        3'd0:    rgb_nxt = 24'hFFFFFF;
        3'd1:    rgb_nxt = 24'hFFFF00;
        3'd2:    rgb_nxt = 24'h00FFFF;
        3'd3:    rgb_nxt = 24'h00FF00;
        3'd4:    rgb_nxt = 24'hFF00FF;
        3'd5:    rgb_nxt = 24'hFF0000;
        3'd6:    rgb_nxt = 24'h0000FF;
        default: rgb_nxt = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_idx   <= '0;
      bar_cnt   <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (en) begin
      bar_idx   <= bar_nxt;
      bar_cnt   <= cnt_nxt;
      red_out   <= rgb_nxt[23:16];
      green_out <= rgb_nxt[15:8];
      blue_out  <= rgb_nxt[7:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      primed          <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      blank_out       <= 1'b1;
      hsync_out       <= ~HSYNC_POL;
      vsync_out       <= ~VSYNC_POL;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end else if (en) begin
      primed          <= 1'b1;
      x_out           <= x_nxt;
      y_out           <= y_nxt;
      blank_out       <= blank_nxt;
      hsync_out       <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_out       <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
      line_start_out  <= (x_nxt == '0);
      frame_start_out <= (x_nxt == '0) && (y_nxt == '0);
    end else begin
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a shrunk raster (active-low syncs) and the default raster
// (active-high syncs) driven by shared random en/rst, compared against a position model.
module tb_video_timing_gen;

  // small raster
  localparam int S_HA = 64, S_HF = 4, S_HS = 8, S_HB = 6;
  localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  // default raster
  localparam int D_HT = 800, D_VT = 525;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] s_x, s_y;
  logic        d_blank, d_hs, d_vs, d_ls, d_fs;
  logic [11:0] d_x, d_y;
`ifdef VTG_TEST_PATTERN_EN
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .COORD_W(8), .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .blank_out(s_blank), .hsync_out(s_hs), .vsync_out(s_vs),
    .x_out(s_x), .y_out(s_y),
    .line_start_out(s_ls), .frame_start_out(s_fs)
`ifdef VTG_TEST_PATTERN_EN
    , .red_out(s_r), .green_out(s_g), .blue_out(s_b)
`endif
  );

  video_timing_gen #(
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_d (
    .clk(clk), .rst(rst), .en(en),
    .blank_out(d_blank), .hsync_out(d_hs), .vsync_out(d_vs),
    .x_out(d_x), .y_out(d_y),
    .line_start_out(d_ls), .frame_start_out(d_fs)
`ifdef VTG_TEST_PATTERN_EN
    , .red_out(d_r), .green_out(d_g), .blue_out(d_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference position state: primed flag, position, and whether the last edge entered a new position.
  bit s_p = 0, s_e = 0, d_p = 0, d_e = 0;
  int s_mx = 0, s_my = 0, d_mx = 0, d_my = 0;

  task automatic model_adv(input bit r, input bit e, input int ht, input int vt,
                           input bit p_i, input int x_i, input int y_i,
                           output bit p_o, output bit ent, output int x_o, output int y_o);
    p_o = p_i; x_o = x_i; y_o = y_i; ent = 0;
    if (r) begin
      p_o = 0; x_o = 0; y_o = 0;
    end else if (e) begin
      ent = 1;
      if (!p_i) begin
        p_o = 1; x_o = 0; y_o = 0;
      end else begin
        x_o = (x_i + 1) % ht;
        if (x_o == 0) y_o = (y_i + 1) % vt;
      end
    end
  endtask

  function automatic logic [23:0] bar_colour(input int h, input int ha);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[h / (ha / 8)];
  endfunction

  task automatic check_inst(input string n, input int ha, input int hf, input int hs,
                            input int va, input int vf, input int vs,
                            input bit hpol, input bit vpol,
                            input bit p, input bit ent, input int mx, input int my,
                            input int gx, input int gy, input bit gblank, input bit ghs,
                            input bit gvs, input bit gls, input bit gfs, input logic [23:0] grgb);
    bit eb, ehs, evs, els, efs;
    logic [23:0] ergb;
    if (!p) begin
      eb = 1; ehs = ~hpol; evs = ~vpol; els = 0; efs = 0;
    end else begin
      eb  = (mx >= ha) || (my >= va);
      ehs = ((mx >= ha + hf) && (mx < ha + hf + hs)) ? hpol : ~hpol;
      evs = ((my >= va + vf) && (my < va + vf + vs)) ? vpol : ~vpol;
      els = ent && (mx == 0);
      efs = ent && (mx == 0) && (my == 0);
    end
    ergb = eb ? 24'h0 : bar_colour(mx, ha);
    check({n, ".x"}, gx, mx);
    check({n, ".y"}, gy, my);
    check({n, ".blank"}, gblank, eb);
    check({n, ".hsync"}, ghs, ehs);
    check({n, ".vsync"}, gvs, evs);
    check({n, ".line_start"}, gls, els);
    check({n, ".frame_start"}, gfs, efs);
`ifdef VTG_TEST_PATTERN_EN
    check({n, ".rgb"}, grgb, ergb);
`else
    if (grgb !== 24'h0) check({n, ".rgb_unused"}, grgb, 24'h0);
`endif
  endtask

  int cyc = 0;
  bit measure = 0;
  int last_sfs = -1, last_sls = -1, last_dls = -1;

  task automatic step(input bit r, input bit e);
    logic [23:0] srgb, drgb;
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    cyc++;
    model_adv(r, e, S_HT, S_VT, s_p, s_mx, s_my, s_p, s_e, s_mx, s_my);
    model_adv(r, e, D_HT, D_VT, d_p, d_mx, d_my, d_p, d_e, d_mx, d_my);
`ifdef VTG_TEST_PATTERN_EN
    srgb = {s_r, s_g, s_b};
    drgb = {d_r, d_g, d_b};
`else
    srgb = 24'h0;
    drgb = 24'h0;
`endif
    check_inst("s", S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b0, 1'b0, s_p, s_e, s_mx, s_my,
               int'(s_x), int'(s_y), s_blank, s_hs, s_vs, s_ls, s_fs, srgb);
    check_inst("d", 640, 16, 96, 480, 10, 2, 1'b1, 1'b1, d_p, d_e, d_mx, d_my,
               int'(d_x), int'(d_y), d_blank, d_hs, d_vs, d_ls, d_fs, drgb);
    if (measure) begin
      if (s_fs) begin
        if (last_sfs >= 0) check("s.frame_period", cyc - last_sfs, S_HT * S_VT);
        last_sfs = cyc;
      end
      if (s_ls) begin
        if (last_sls >= 0) check("s.line_period", cyc - last_sls, S_HT);
        last_sls = cyc;
      end
      if (d_ls) begin
        if (last_dls >= 0) check("d.line_period", cyc - last_dls, D_HT);
        last_dls = cyc;
      end
    end
  endtask

  initial begin
    step(1, 0);
    step(1, 1);
    step(0, 0);
    measure = 1;
    for (int i = 0; i < 2 * S_HT * S_VT + 20; i++) step(0, 1);
    measure = 0;
    // random enable gaps and occasional mid-frame resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0));
    end
    // long hold, then resume
    for (int i = 0; i < 5; i++) step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
